// File: rtl/ddr3_rw_sched.sv
// ddr3_rw_sched: fill-level arbiter moving write-FIFO bursts into DDR3 and DDR3 bursts into the read FIFO.
// Ping-pong frame banks are swapped on synced wr_load edges, only between bursts.
module ddr3_rw_sched #(
    parameter int BURST_LEN = 64,
    parameter int ADDR_STEP = 8,
    parameter int FRAME_MAX = 192000,
    parameter int BANK_BIT  = 24,
    parameter int RD_TH     = 512
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic        init_calib_complete,
    input  logic        wr_load,
    input  logic        rd_load,
    input  logic        rd_enable,
    input  logic [10:0] wfifo_rcount,
    input  logic [10:0] rfifo_wcount,
    output logic        wfifo_rden,
    output logic        rfifo_wren,
    input  logic        app_rdy,
    input  logic        app_wdf_rdy,
    input  logic        app_rd_data_valid,
    output logic        app_en,
    output logic [2:0]  app_cmd,
    output logic [27:0] app_addr,
    output logic        app_wdf_wren,
    output logic        app_wdf_end
);
    localparam logic [7:0] BL = 8'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ARB, WRITE, READ} state_t;
    state_t state, state_nxt;

    logic [2:0]  wr_sync, rd_sync;
    logic        wr_pend, rd_pend, wbank, rbank, last_rd;
    logic [7:0]  cmd_cnt, dat_cnt;
    logic [27:0] wr_off, rd_off, addr_base, off_inc, off_nxt;
    logic        cmd_acc, dat_acc, wr_ok, rd_ok, grant_wr, grant_rd, burst_done;

    always_comb begin
        app_en       = (state == WRITE || state == READ) && cmd_cnt < BL;
        app_cmd      = state == READ ? 3'b001 : 3'b000;
        app_wdf_wren = state == WRITE && dat_cnt < BL;
        app_wdf_end  = app_wdf_wren;
        wfifo_rden   = app_wdf_wren && app_wdf_rdy;
        rfifo_wren   = state == READ && app_rd_data_valid;
        cmd_acc      = app_en && app_rdy;
        dat_acc      = state == WRITE ? wfifo_rden : rfifo_wren;
        addr_base    = state == READ ? rd_off : wr_off;
        off_inc      = addr_base + 28'(ADDR_STEP);
        off_nxt      = off_inc >= 28'(FRAME_MAX) ? '0 : off_inc;
        app_addr     = addr_base;
        app_addr[BANK_BIT] = state == READ ? rbank : wbank;
        wr_ok        = wfifo_rcount >= 11'(BURST_LEN);
        rd_ok        = rd_enable && rfifo_wcount < 11'(RD_TH);
        grant_wr     = wr_ok && (!rd_ok || last_rd);
        grant_rd     = rd_ok && !grant_wr;
        // exit on the edge that completes the burst so ARB costs exactly one cycle
        burst_done   = 8'(cmd_cnt + 8'(cmd_acc)) == BL && 8'(dat_cnt + 8'(dat_acc)) == BL;
        state_nxt    = state;
        if (state == IDLE && init_calib_complete)
            state_nxt = ARB;
        else if (state == ARB)
            state_nxt = grant_wr ? WRITE : grant_rd ? READ : ARB;
        else if ((state == WRITE || state == READ) && burst_done)
            state_nxt = ARB;
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_sync <= '0;
            rd_sync <= '0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            wbank   <= 1'b0;
            rbank   <= 1'b1;
            last_rd <= 1'b1;
            cmd_cnt <= '0;
            dat_cnt <= '0;
            wr_off  <= '0;
            rd_off  <= '0;
        end else begin
            state   <= state_nxt;
            wr_sync <= {wr_sync[1:0], wr_load};
            rd_sync <= {rd_sync[1:0], rd_load};
            wr_pend <= (wr_sync[1] && !wr_sync[2]) || (wr_pend && state != ARB);
            rd_pend <= (rd_sync[1] && !rd_sync[2]) || (rd_pend && state != ARB);
            cmd_cnt <= state == ARB ? '0 : 8'(cmd_cnt + 8'(cmd_acc));
            dat_cnt <= state == ARB ? '0 : 8'(dat_cnt + 8'(dat_acc));
            if (cmd_acc && state == WRITE)
                wr_off <= off_nxt;
            if (cmd_acc && state == READ)
                rd_off <= off_nxt;
            // the read side follows the frame the writer just finished
            if (state == ARB && wr_pend) begin
                wr_off <= '0;
                wbank  <= ~wbank;
                rbank  <= wbank;
            end
            if (state == ARB && rd_pend)
                rd_off <= '0;
            if (state == ARB && (grant_wr || grant_rd))
                last_rd <= grant_rd;
        end
    end
endmodule
